// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, default sizing and midscale helper for the SAR controller.
package sar_pkg;

    localparam int unsigned SAR_N             = 8;
    localparam int unsigned SAR_SAMPLE_CYCLES = 2;
    localparam int unsigned SAR_MAX_N         = 16;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    // First trial code of a conversion: MSB set, all lower bits clear.
    function automatic logic [SAR_MAX_N-1:0] midscale(input int unsigned n);
        return SAR_MAX_N'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/sar_ctrl_if.sv
// sar_ctrl_if: conversion handshake, comparator decision and DAC/result buses of the SAR controller.
interface sar_ctrl_if #(
    parameter int unsigned N = sar_pkg::SAR_N
);
    logic         start;
    logic         cmp_out;
    logic         busy;
    logic         sample;
    logic         amp_en;
    logic [N-1:0] dac_code;
    logic [N-1:0] dout;
    logic         done;

    modport master (
        input  start, cmp_out,
        output busy, sample, amp_en, dac_code, dout, done
    );

    modport slave (
        output start, cmp_out,
        input  busy, sample, amp_en, dac_code, dout, done
    );
endinterface

// File: rtl/sar_bit_ptr.sv
// sar_bit_ptr: down-counting bit pointer for the SAR trial bit, with one-hot decode.
module sar_bit_ptr #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic         dec,
    output logic         last,
    output logic [N-1:0] onehot_k
);
    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr <= PW'(N - 1);
        end else if (load) begin
            ptr <= PW'(N - 1);
        end else if (dec && (ptr != '0)) begin
            ptr <= ptr - PW'(1);
        end
    end

    assign last     = (ptr == '0);
    assign onehot_k = N'(1) << ptr;

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: SAR ADC sequencer - track/hold, one trial bit per clock, result capture with done pulse.
// Define SAR_CONT_EN for continuous conversions while start stays high.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned N             = SAR_N,
    parameter int unsigned SAMPLE_CYCLES = SAR_SAMPLE_CYCLES
) (
    input  logic       clk,
    input  logic       rstb,
    sar_ctrl_if.master bus
);
    localparam int unsigned   CW       = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [N-1:0]  MID      = N'(midscale(N));

    sar_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic [N-1:0]  code, code_next;
    logic [N-1:0]  onehot;
    logic          ptr_load, ptr_dec, ptr_last;
    logic [N-1:0]  dout_q;
    logic          busy_q, sample_q, amp_q, done_q;

    sar_bit_ptr #(.N(N)) u_ptr (
        .clk      (clk),
        .rstb     (rstb),
        .load     (ptr_load),
        .dec      (ptr_dec),
        .last     (ptr_last),
        .onehot_k (onehot)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        code_next  = MID;
        ptr_load   = 1'b0;
        ptr_dec    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = SAMPLE;
            SAMPLE: begin
                if (cnt == '0) begin
                    state_next = CONV;
                    ptr_load   = 1'b1;
                end
            end
            CONV: begin
                // Resolve trial bit k with the latched decision, then arm bit k-1.
                code_next = (code & ~onehot) | (bus.cmp_out ? onehot : '0);
                if (ptr_last) begin
                    state_next = DONE;
                end else begin
                    code_next = code_next | (onehot >> 1);
                    ptr_dec   = 1'b1;
                end
            end
            DONE: begin
`ifdef SAR_CONT_EN
                state_next = bus.start ? SAMPLE : IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if ((state_next == SAMPLE) && (state != SAMPLE)) begin
            cnt <= CNT_LOAD;
        end else if ((state == SAMPLE) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            code     <= MID;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            amp_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            code     <= code_next;
            busy_q   <= (state_next != IDLE) || (state == DONE);
            sample_q <= (state_next == SAMPLE);
            amp_q    <= (state_next == CONV);
            done_q   <= (state_next == DONE);
            if (state_next == DONE) dout_q <= code_next;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.sample   = sample_q;
    assign bus.amp_en   = amp_q;
    assign bus.done     = done_q;
    assign bus.dac_code = code;
    assign bus.dout     = dout_q;

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation control logic for the SAR ADC, directly downstream of the clocked integrating preamp and its regenerative latch. It sequences track/hold, steps a binary trial code into the capacitive DAC one bit per clock, samples the latched comparator decision each bit cycle, and delivers the final N-bit code with a done pulse. It shares the preamp's sampling clock, so one bit is resolved per clock period.

## Interface
- N, 8, conversion resolution in bits (2..16)
- SAMPLE_CYCLES, 2, clock cycles the track switch stays closed (>=1)
- clk  input  1  conversion clock; same clock as the integrating preamp
- rstb  input  1  asynchronous active-low reset
- start  input  1  request one conversion; sampled on the rising clk edge
- cmp_out  input  1  latched comparator decision, 1 means vinp > vinn for the current trial code
- busy  output  1  high from accepted start until done
- sample  output  1  track switch enable (1 = tracking)
- amp_en  output  1  enables preamp integration for the current bit cycle
- dac_code  output  N  trial code driven to the capacitive DAC
- dout  output  N  last completed conversion result, held until the next done
- done  output  1  one-cycle pulse when dout updates

## Operation
- States: IDLE, SAMPLE, CONV, DONE. The state enum lives in the package.
- IDLE: busy=0, sample=0, amp_en=0. start=1 goes to SAMPLE. dac_code is set to the midscale trial code, 1 followed by N-1 zeros.
- SAMPLE: sample=1, busy=1. Stay for exactly SAMPLE_CYCLES cycles, counted by a sample counter, then go to CONV. On entry to CONV, set the bit pointer to N-1 and dac_code to midscale.
- CONV: amp_en=1, sample=0. Each cycle has pointer k and trial bit k = 1 in dac_code. At the clk edge:
  - dac_code[k] <= cmp_out.
  - If k>0, dac_code[k-1] <= 1 and the pointer decrements.
  - If k==0, go to DONE.
- DONE: lasts one cycle. dout <= dac_code (all decisions resolved), done=1, busy stays 1. The next state is IDLE.
- start is ignored while busy=1. It is not queued.
- A start level held continuously re-triggers from IDLE, giving one conversion per SAMPLE_CYCLES+N+2 cycles.
- Reset asserted at any time, including mid-CONV, forces IDLE immediately (asynchronous). The partial code is discarded and dout is cleared.
- Arithmetic: no adders. The pointer is ceil(log2 N) bits wide and the sample counter is ceil(log2(SAMPLE_CYCLES+1)) bits wide. Neither wraps; both are loaded on state entry.

## Timing
- Reset values:
  - busy=0, sample=0, amp_en=0, done=0, dout=0.
  - dac_code = midscale (MSB only set).
  - state = IDLE.
- Start accepted at edge E0 gives sample=1 on cycles E0+1 .. E0+SAMPLE_CYCLES.
- CONV runs cycles E0+SAMPLE_CYCLES+1 .. E0+SAMPLE_CYCLES+N. cmp_out is sampled at the end of each of these cycles.
- done pulses, and dout is valid, in cycle E0+SAMPLE_CYCLES+N+1. busy falls the cycle after.
- cmp_out must be stable at the rising edge ending each CONV cycle. The preamp integrates during the high phase and the latch resolves before the next edge.
- All outputs are registered. No combinational path from cmp_out or start to any output.

## Configuration
- SAR_CONT_EN defined: continuous mode. DONE transitions directly to SAMPLE, with busy held at 1, and start is needed only for the first conversion. Deasserting start in DONE returns to IDLE after that conversion.
- SAR_CONT_EN undefined: single-shot behaviour as above. Every conversion requires start seen in IDLE.

## Structure
- Package sar_pkg holds:
  - the state enum (IDLE, SAMPLE, CONV, DONE);
  - the default N and SAMPLE_CYCLES constants;
  - a midscale(N) constant function.
- Sub-module sar_bit_ptr holds the down-counting bit pointer. Its signals:
  - load: initialize to N-1;
  - dec: decrement one position;
  - last: asserted at 0;
  - onehot_k: one-hot pointer used to address dac_code.
- The FSM, sample counter and code register are in sar_ctrl.

## Test plan
- Reset mid-CONV at bit 4 (N=8): within the reset all outputs take their reset values, dac_code=8'h80, and no done pulse follows.
- N=8, SAMPLE_CYCLES=2, cmp_out pattern 1,0,1,1,0,0,1,0 from MSB: dout=8'hB2, done exactly 11 cycles after the start edge, and the dac_code trajectory is 80,C0,A0,B0,B8,B4,B2,B3 → final B2.
- cmp_out held 0: dout=8'h00. cmp_out held 1: dout=8'hFF. In both cases busy is high for 12 cycles.
- start pulsed again during CONV: ignored, dout unchanged until the first conversion's done, and there is no second conversion.
- SAR_CONT_EN with start held: back-to-back conversions every 11 cycles with no IDLE cycle. Dropping start in a DONE cycle ends the sequence after that conversion.
- Closed-loop bench with clk_integrating_amp and a latch model: sine input at 21.394 MHz, 150 mV amplitude, 1.2 V common mode, 500 MHz clk. The dout sequence tracks the sine with error ≤1 LSB against the ideal quantizer.
